// File: rtl/mfcc_vector_collector_pkg.sv
// Shared constants for the MFCC feature-vector collector.
// EPS is a small float32 floor kept here for downstream log/normalisation stages.
package mfcc_vector_collector_pkg;
    localparam int VEC_LEN = 26;
    localparam int GAP_MAX = 64;
    localparam int IDX_W   = 5;
    localparam int FLOAT_W = 32;
    localparam logic [FLOAT_W-1:0] EPS = 32'h25800000;
endpackage

// File: rtl/mfcc_pingpong_bank.sv
// Two-bank register store for feature vectors: one write port, one combinational
// read mux, and a full flag per bank. Only the flags are reset; data is not.
module mfcc_pingpong_bank
    import mfcc_vector_collector_pkg::*;
#(
    parameter int VEC_LEN = 26,
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic              i_wr_bank,
    input  logic [IDX_W-1:0]  i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_set_full,
    input  logic              i_set_bank,
    input  logic              i_clr_full,
    input  logic              i_clr_bank,
    input  logic              i_rd_bank,
    input  logic [IDX_W-1:0]  i_rd_idx,
    output logic [1:0]        o_full,
    output logic [DATA_W-1:0] o_rd_data
);
    logic [DATA_W-1:0] r_mem [2][VEC_LEN];
    logic [1:0]        r_full;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_bank][i_wr_idx] <= i_wr_data;
        end
    end

    // Set and clear always address different banks, so both may fire together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= 2'b00;
        end else begin
            if (i_set_full) r_full[i_set_bank] <= 1'b1;
            if (i_clr_full) r_full[i_clr_bank] <= 1'b0;
        end
    end

    assign o_full    = r_full;
    assign o_rd_data = r_mem[i_rd_bank][i_rd_idx];
endmodule

// File: rtl/mfcc_vector_collector.sv
// Collects the unstallable float32 MFCC word stream into whole vectors in a
// ping-pong store and replays each as a valid/ready/last framed stream.
module mfcc_vector_collector
    import mfcc_vector_collector_pkg::*;
#(
    parameter int VEC_LEN = mfcc_vector_collector_pkg::VEC_LEN,
    parameter int GAP_MAX = mfcc_vector_collector_pkg::GAP_MAX,
    parameter int IDX_W   = mfcc_vector_collector_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tvalid_mfcc_vector_features,
    input  logic [FLOAT_W-1:0] mfcc_vector_features,
    output logic               m_tvalid,
    input  logic               m_tready,
    output logic [FLOAT_W-1:0] m_tdata,
    output logic               m_tlast,
    output logic [IDX_W-1:0]   m_index,
    output logic [15:0]        vec_count,
    output logic [7:0]         drop_count,
    output logic               overflow,
    output logic               sync_err
);
    localparam int GAP_W = $clog2(GAP_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_MAX - 1);

    logic               r_wb, r_rb, r_drop;
    logic [IDX_W-1:0]   r_widx, r_ridx;
    logic [GAP_W-1:0]   r_gap;
    logic [15:0]        r_vec_count;
    logic [7:0]         r_drop_count;
    logic               r_overflow, r_sync_err;

    logic [1:0]         w_full;
    logic [FLOAT_W-1:0] w_rd_data;
    logic               w_word, w_drop_now, w_end, w_wr_en, w_commit, w_timeout;
    logic               w_valid, w_last, w_rd_fire, w_rd_done;

    // Drop decision is taken on word 0 from the registered flag, so a bank
    // being released this very cycle still counts as occupied.
    always_comb begin
        w_word     = tvalid_mfcc_vector_features;
        w_drop_now = r_drop || ((r_widx == '0) && w_full[r_wb]);
        w_end      = w_word && (r_widx == LAST_IDX);
        w_wr_en    = w_word && !w_drop_now;
        w_commit   = w_end && !w_drop_now;
        w_timeout  = !w_word && (r_widx != '0) && (r_gap == GAP_LAST);
        w_valid    = w_full[r_rb];
        w_last     = w_valid && (r_ridx == LAST_IDX);
        w_rd_fire  = w_valid && m_tready;
        w_rd_done  = w_rd_fire && w_last;
    end

    mfcc_pingpong_bank #(
        .VEC_LEN (VEC_LEN),
        .IDX_W   (IDX_W),
        .DATA_W  (FLOAT_W)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_en),
        .i_wr_bank  (r_wb),
        .i_wr_idx   (r_widx),
        .i_wr_data  (mfcc_vector_features),
        .i_set_full (w_commit),
        .i_set_bank (r_wb),
        .i_clr_full (w_rd_done),
        .i_clr_bank (r_rb),
        .i_rd_bank  (r_rb),
        .i_rd_idx   (r_ridx),
        .o_full     (w_full),
        .o_rd_data  (w_rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wb         <= 1'b0;
            r_widx       <= '0;
            r_gap        <= '0;
            r_drop       <= 1'b0;
            r_vec_count  <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
            r_sync_err   <= 1'b0;
        end else if (w_word) begin
            r_gap <= '0;
            if (w_end) begin
                r_widx <= '0;
                r_drop <= 1'b0;
                if (w_drop_now) begin
                    if (r_drop_count != 8'hFF) r_drop_count <= r_drop_count + 8'd1;
                    r_overflow <= 1'b1;
                end else begin
                    r_wb        <= ~r_wb;
                    r_vec_count <= r_vec_count + 16'd1;
                end
            end else begin
                r_widx <= r_widx + IDX_W'(1);
                r_drop <= w_drop_now;
            end
        end else if (w_timeout) begin
            // Partial vector is abandoned in place; the bank is never committed.
            r_widx     <= '0;
            r_drop     <= 1'b0;
            r_gap      <= '0;
            r_sync_err <= 1'b1;
        end else if (r_widx != '0) begin
            r_gap <= r_gap + GAP_W'(1);
        end else begin
            r_gap <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rb   <= 1'b0;
            r_ridx <= '0;
        end else if (w_rd_fire) begin
            if (w_last) begin
                r_rb   <= ~r_rb;
                r_ridx <= '0;
            end else begin
                r_ridx <= r_ridx + IDX_W'(1);
            end
        end
    end

    assign m_tvalid   = w_valid;
    assign m_tdata    = w_valid ? w_rd_data : '0;
    assign m_tlast    = w_last;
    assign m_index    = r_ridx;
    assign vec_count  = r_vec_count;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;
    assign sync_err   = r_sync_err;
endmodule

// File: tb/tb_mfcc_vector_collector.sv
// Bench for mfcc_vector_collector: table of single-vector streams plus
// hand-written backpressure, overflow, gap and reset sequences.
`timescale 1ns/1ps
module tb_mfcc_vector_collector;
    localparam int VL = 26;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tvalid = 1'b0;
    logic [31:0] tdata = '0;
    logic        m_tvalid, m_tready, m_tlast, overflow, sync_err;
    logic [31:0] m_tdata;
    logic [4:0]  m_index;
    logic [15:0] vec_count;
    logic [7:0]  drop_count;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  idx;
        logic        last;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [31:0] base;
        logic [31:0] step;
        int          idle;
        logic [15:0] exp_vc;
    } vec_t;
    vec_t tbl[5];

    always #5 clk = ~clk;

    mfcc_vector_collector dut (
        .clk                         (clk),
        .rst                         (rst),
        .tvalid_mfcc_vector_features (tvalid),
        .mfcc_vector_features        (tdata),
        .m_tvalid                    (m_tvalid),
        .m_tready                    (m_tready),
        .m_tdata                     (m_tdata),
        .m_tlast                     (m_tlast),
        .m_index                     (m_index),
        .vec_count                   (vec_count),
        .drop_count                  (drop_count),
        .overflow                    (overflow),
        .sync_err                    (sync_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Scoreboard pop on every accepted beat, plus hold-stability during stalls.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d;
    logic [4:0]  prev_i;
    logic        prev_l;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && m_tvalid) begin
                chk("stall_data", m_tdata, prev_d);
                chk("stall_idx", {27'd0, m_index}, {27'd0, prev_i});
                chk("stall_last", {31'd0, m_tlast}, {31'd0, prev_l});
            end
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) begin
                    chk("unexpected_beat", m_tdata, 32'hDEADBEEF ^ m_tdata ^ 32'h1);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", m_tdata, e.d);
                    chk("out_idx", {27'd0, m_index}, {27'd0, e.idx});
                    chk("out_last", {31'd0, m_tlast}, {31'd0, e.last});
                end
            end
            prev_stall <= m_tvalid && !m_tready;
            prev_d     <= m_tdata;
            prev_i     <= m_index;
            prev_l     <= m_tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [31:0] base, input logic [31:0] step,
                            input int n, input int idle, input bit push);
        if (push) begin
            for (int i = 0; i < n; i++) begin
                exp_t e;
                e.d    = base + 32'(i) * step;
                e.idx  = 5'(i);
                e.last = (i == VL - 1);
                q.push_back(e);
            end
        end
        for (int i = 0; i < n; i++) begin
            tvalid = 1'b1;
            tdata  = base + 32'(i) * step;
            tick();
            if (idle > 0 && i < n - 1) begin
                tvalid = 1'b0;
                repeat (idle) tick();
            end
        end
        tvalid = 1'b0;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int c = 0;
        while ((q.size() != 0 || m_tvalid) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: drain timeout, %0d words outstanding, required 0", nm, q.size());
        end
    endtask

    task automatic check_idle_zero(input string nm);
        chk({nm, "_tvalid"}, {31'd0, m_tvalid}, 32'd0);
        chk({nm, "_tlast"}, {31'd0, m_tlast}, 32'd0);
        chk({nm, "_index"}, {27'd0, m_index}, 32'd0);
        chk({nm, "_tdata"}, m_tdata, 32'd0);
        chk({nm, "_vec_count"}, {16'd0, vec_count}, 32'd0);
        chk({nm, "_drop_count"}, {24'd0, drop_count}, 32'd0);
        chk({nm, "_overflow"}, {31'd0, overflow}, 32'd0);
        chk({nm, "_sync_err"}, {31'd0, sync_err}, 32'd0);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        tvalid = 1'b0;
        repeat (2) tick();
        q.delete();
        rst = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{32'h3F800000, 32'h00000001, 0, 16'd1};
        tbl[1] = '{32'hBF000000, 32'h00000100, 0, 16'd2};
        tbl[2] = '{32'h00000000, 32'h01010101, 2, 16'd3};
        tbl[3] = '{32'h7F7FFFF0, 32'hFFFFFFFF, 5, 16'd4};
        tbl[4] = '{32'h40490FDB, 32'h00000010, 63, 16'd5};

        m_tready = 1'b1;
        repeat (3) tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();

        for (int k = 0; k < 5; k++) begin
            send_vec(tbl[k].base, tbl[k].step, VL, tbl[k].idle, 1'b1);
            if (k == 0) begin
                chk("latency_tvalid", {31'd0, m_tvalid}, 32'd1);
                chk("latency_word0", m_tdata, tbl[k].base);
            end
            wait_drain("table", 200);
            chk("table_vec_count", {16'd0, vec_count}, {16'd0, tbl[k].exp_vc});
            chk("table_sync_err", {31'd0, sync_err}, 32'd0);
            chk("table_overflow", {31'd0, overflow}, 32'd0);
        end

        // Backpressure: two vectors buffered, then a toggling ready.
        do_reset();
        m_tready = 1'b0;
        send_vec(32'h3E000000, 32'h3, VL, 0, 1'b1);
        send_vec(32'hC1200000, 32'h7, VL, 0, 1'b1);
        chk("bp_vec_count", {16'd0, vec_count}, 32'd2);
        chk("bp_tvalid", {31'd0, m_tvalid}, 32'd1);
        chk("bp_hold_word0", m_tdata, 32'h3E000000);
        repeat (5) tick();
        for (int c = 0; c < 400 && (q.size() != 0 || m_tvalid); c++) begin
            m_tready = ~m_tready;
            tick();
        end
        chk("bp_drained", q.size(), 32'd0);
        chk("bp_overflow", {31'd0, overflow}, 32'd0);

        // Overflow: third vector with both banks full is dropped whole.
        do_reset();
        m_tready = 1'b0;
        send_vec(32'h11110000, 32'h1, VL, 0, 1'b1);
        send_vec(32'h22220000, 32'h1, VL, 0, 1'b1);
        send_vec(32'h33330000, 32'h1, VL, 0, 1'b0);
        chk("ovf_drop_count", {24'd0, drop_count}, 32'd1);
        chk("ovf_overflow", {31'd0, overflow}, 32'd1);
        chk("ovf_vec_count", {16'd0, vec_count}, 32'd2);
        m_tready = 1'b1;
        wait_drain("ovf", 200);
        repeat (3) tick();
        chk("ovf_no_extra", {31'd0, m_tvalid}, 32'd0);

        // Gap timeout: partial vector discarded, next one clean.
        do_reset();
        m_tready = 1'b1;
        send_vec(32'hAAAA0000, 32'h1, 10, 0, 1'b0);
        repeat (64) tick();
        chk("gap_sync_err", {31'd0, sync_err}, 32'd1);
        chk("gap_vec_count_0", {16'd0, vec_count}, 32'd0);
        send_vec(32'hBBBB0000, 32'h2, VL, 0, 1'b1);
        wait_drain("gap", 200);
        chk("gap_vec_count_1", {16'd0, vec_count}, 32'd1);

        // Reset in the middle of a readout.
        do_reset();
        m_tready = 1'b0;
        send_vec(32'hCCCC0000, 32'h5, VL, 0, 1'b1);
        m_tready = 1'b1;
        for (int c = 0; c < 100 && q.size() > VL - 13; c++) tick();
        chk("mid_words_out", q.size(), 32'(VL - 13));
        rst = 1'b1;
        q.delete();
        tick();
        check_idle_zero("mid_reset");
        rst = 1'b0;
        send_vec(32'hDDDD0000, 32'h9, VL, 0, 1'b1);
        wait_drain("mid_fresh", 200);
        chk("mid_vec_count", {16'd0, vec_count}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mfcc_vector_collector.md
Name: mfcc_vector_collector

Overview:
- Consumer end of the MFCC feature stream. Takes the headerless 32-bit float word stream (tvalid pulse per word, no backpressure), realigns it into fixed-length feature vectors, and buffers them in a ping-pong store.
- Re-emits each vector as a handshaked, framed word stream (valid/ready/last) for the VAD classifier.
- Detects overflow and intra-vector timing gaps.

Parameters:
- VEC_LEN, 26, 32-bit words per feature vector (13 MFCC incl. log-energy + 13 deltas).
- GAP_MAX, 64, max idle clk cycles allowed between words inside one vector.
- IDX_W, 5, width of word index; must satisfy 2**IDX_W >= VEC_LEN.

Ports:
- clk  in  1  system clock (g_clk domain).
- rst  in  1  synchronous active-high reset.
- tvalid_mfcc_vector_features  in  1  input word strobe; cannot be stalled.
- mfcc_vector_features  in  32  input IEEE-754 float32 word.
- m_tvalid  out  1  output word valid.
- m_tready  in  1  downstream accept.
- m_tdata  out  32  output word.
- m_tlast  out  1  high on word VEC_LEN-1 of a vector.
- m_index  out  IDX_W  index of current output word.
- vec_count  out  16  vectors committed, wraps at 65535→0.
- drop_count  out  8  vectors dropped for overflow, saturates at 255.
- overflow  out  1  sticky: at least one vector dropped.
- sync_err  out  1  sticky: at least one gap timeout occurred.

Behaviour:
- Reset (synchronous): m_tvalid=0, m_tlast=0, m_index=0, m_tdata=0, vec_count=0, drop_count=0, overflow=0, sync_err=0. Both bank full flags cleared; write bank = read bank = 0; write index = 0; gap counter = 0; drop mode off. Reset mid-vector or mid-readout discards all buffered data. Sticky flags clear only on reset.
- Storage: two banks of VEC_LEN x 32 registers. Write side uses wb, widx, full[1:0].
- Write, accepted word (tvalid=1):
  - If widx==0, evaluate full[wb] as registered at that cycle start. A bank being freed in the same cycle counts as full.
  - If full[wb]=1: enter drop mode for the whole vector.
  - Otherwise store the word at bank[wb][widx].
  - widx increments each word, including in drop mode.
- End of vector (widx==VEC_LEN-1 with a word):
  - Normal: full[wb]<=1, wb toggles, widx<=0, vec_count++.
  - Drop mode: no commit; drop_count++ (saturating), overflow<=1, drop mode clears, widx<=0.
- Gap timeout:
  - Gap counter clears on every input word and increments otherwise while widx!=0.
  - When it reaches GAP_MAX: widx<=0, drop mode cleared, partial vector discarded (bank not committed), sync_err<=1, counter<=0.
  - A word arriving in the same cycle the counter would reach GAP_MAX is accepted; no timeout that cycle.
- Read side (rb, ridx):
  - m_tvalid = full[rb].
  - m_tdata = bank[rb][ridx], first-word fall-through (combinational mux from registers).
  - m_index = ridx; m_tlast = m_tvalid && ridx==VEC_LEN-1.
  - On m_tvalid && m_tready: ridx++. If m_tlast: full[rb]<=0, rb toggles, ridx<=0.
  - m_tdata/m_tlast/m_index must stay stable while m_tvalid=1 and m_tready=0.
- Latency:
  - Last input word at cycle t → m_tvalid=1 at cycle t+1, with word 0 presented.
  - At most one output word per cycle; minimum VEC_LEN cycles per vector.
- Simultaneous events: in the same cycle, a commit to bank A and the final read of bank B both take effect. full[] updates for set and clear never target the same bank in one cycle.
- Both banks full: downstream stalled ≥ 2 vectors. Subsequent vectors are dropped whole; no partial or torn vectors ever reach the output.

Decomposition:
- Shared package: VEC_LEN, GAP_MAX, IDX_W defaults; FLOAT_W=32; EPS float constant 32'h25800000 for downstream use.
- One natural sub-module: mfcc_pingpong_bank (two-bank register store, write port, read mux, full flags).
- The top keeps write/drop/gap control, read handshake and counters.

Test Plan:
- Basic: 26 words (0x3F800000+i) on consecutive cycles, m_tready=1 → m_tvalid rises 1 cycle after word 25. Words are output in order, m_tlast on index 25, vec_count=1.
- Backpressure: stream 2 vectors, m_tready=0, then toggle m_tready every other cycle → all 52 words are delivered unchanged, holding stable during stalls. overflow=0.
- Overflow: 3 vectors back-to-back with m_tready=0 → vectors 1–2 are buffered, vector 3 is dropped. drop_count=1, overflow=1, vec_count=2. Later output is exactly vectors 1 and 2.
- Gap timeout: 10 words, idle 64 cycles, then 26 words → sync_err=1 and the partial vector is discarded. The next 26 words form one clean vector, vec_count=1.
- Gap boundary: word arrives exactly GAP_MAX-1 idle cycles after the previous one → no sync_err, the vector completes.
- Reset mid-readout: assert rst after word 12 is output → next cycle all outputs/counters are 0 and m_tvalid=0. A fresh vector afterwards is output correctly from index 0.
